reg_file_mp: RTL and testbench

- Next-generation register file: parametrised width, depth and read-port count.
- Adds a post-reset clear sweep, optional hard-wired zero register, optional write-to-read bypass, and a dropped-write indicator.
- Sits in the datapath between decode (read addresses) and writeback (write port), replacing the fixed two-read-port file.
- Contents need no init file; the array is defined as all-zero once InitBusy falls.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/rf_read_port.sv | 33 +++
 rtl/reg_file_mp.sv | 99 +++++++++
 tb/tb_reg_file_mp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and slicing helpers for the multi-port register file.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package regfile_pkg;

    // Sweep phase of the file: SWEEP while clearing after reset, READY afterwards.
    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } sweep_state_e;

    // LSB offset of packed port 'port' when each port is 'width' bits wide.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// Per-port read mux: init mask, hard-wired zero register, write bypass, array data.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; always returns data for the presented address.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic [D-1:0] raddr_i,
    input  logic [W-1:0] arr_dat_i,
    input  logic         wr_acc_i,
    input  logic [D-1:0] waddr_i,
    input  logic [W-1:0] wdat_i,
    input  logic         init_busy_i,
    output logic [W-1:0] rdat_o
);

    // Priority: init mask, then r0 zero, then same-cycle forwarding, then stored value.
    always_comb begin
        rdat_o = arr_dat_i;
        if (init_busy_i) begin
            rdat_o = '0;
        end else if ((ZERO_R0 != 0) && (raddr_i == '0)) begin
            rdat_o = '0;
        end else if ((BYPASS != 0) && wr_acc_i && (waddr_i == raddr_i)) begin
            rdat_o = wdat_i;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with post-reset clear sweep, optional zero r0 and bypass.
// Latency: reads 0 cycles; writes visible next cycle (same cycle with bypass).
// Backpressure: none; writes during the clear sweep are dropped and flagged on WriteDrop.
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int W       = 8,
    parameter int D       = 4,
    parameter int NR      = 2,
    parameter int ZERO_R0 = 0,
    parameter int BYPASS  = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            WriteEn,
    input  logic [D-1:0]    Waddr,
    input  logic [W-1:0]    DataIn,
    input  logic [NR*D-1:0] Raddr,
    output logic [NR*W-1:0] DataOut,
    output logic            InitBusy,
    output logic            WriteDrop
);

    localparam int         DEPTH    = 2**D;
    localparam logic [D:0] LAST_IDX = (D+1)'(DEPTH-1);

    sweep_state_e state_q, state_d;
    logic [D:0]   cnt_q, cnt_d;
    logic         drop_q, drop_d;
    logic [W-1:0] regs_q [DEPTH];
    logic         init_busy;
    logic         wr_acc;

    assign init_busy = (state_q == SWEEP);

    // A write lands only once the sweep is done and it is not aimed at a hard-wired r0.
    always_comb begin
        wr_acc = WriteEn && !init_busy && !((ZERO_R0 != 0) && (Waddr == '0));
    end

    // Sweep advance and drop flag; the edge clearing the last address ends the sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = WriteEn && init_busy;
        if (state_q == SWEEP) begin
            cnt_d = cnt_q + (D+1)'(1);
            if (cnt_q == LAST_IDX) begin
                state_d = READY;
            end
        end
    end

    // Control state; reset restarts the sweep from address 0 at any time.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    // Storage: cleared one entry per edge during the sweep, otherwise written on acceptance.
    always_ff @(posedge Clk) begin
        if (!Reset && init_busy) begin
            regs_q[cnt_q[D-1:0]] <= '0;
        end else if (wr_acc) begin
            regs_q[Waddr] <= DataIn;
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [D-1:0] raddr;
        assign raddr = Raddr[port_lsb(g, D) +: D];

        rf_read_port #(
            .W       (W),
            .D       (D),
            .ZERO_R0 (ZERO_R0),
            .BYPASS  (BYPASS)
        ) u_rd (
            .raddr_i     (raddr),
            .arr_dat_i   (regs_q[raddr]),
            .wr_acc_i    (wr_acc),
            .waddr_i     (Waddr),
            .wdat_i      (DataIn),
            .init_busy_i (init_busy),
            .rdat_o      (DataOut[port_lsb(g, W) +: W])
        );
    end

    assign InitBusy  = init_busy;
    assign WriteDrop = drop_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (zero-r0 + bypass, plain + no bypass) share stimulus.
// Latency: checks combinational reads mid-cycle, registered flags after each edge.
// Backpressure: n/a.
module tb_reg_file_mp;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int NR = 3;
    localparam int N  = 16;

    logic            Clk;
    logic            Reset;
    logic            WriteEn;
    logic [D-1:0]    Waddr;
    logic [W-1:0]    DataIn;
    logic [NR*D-1:0] Raddr;
    logic [NR*W-1:0] dout_a, dout_b;
    logic            busy_a, busy_b, drop_a, drop_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: sweep progress, drop flag, contents per instance (0 = A, 1 = B).
    int         sweep_pos;
    bit         mdrop;
    logic [7:0] marr [2][N];

    reg_file_mp #(.W(W), .D(D), .NR(NR), .ZERO_R0(1), .BYPASS(1)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .Raddr(Raddr), .DataOut(dout_a), .InitBusy(busy_a), .WriteDrop(drop_a)
    );

    reg_file_mp #(.W(W), .D(D), .NR(NR), .ZERO_R0(0), .BYPASS(0)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .Raddr(Raddr), .DataOut(dout_b), .InitBusy(busy_b), .WriteDrop(drop_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_rd(input int inst, input logic [3:0] a);
        if (sweep_pos < N) return 8'h00;
        if (inst == 0 && a == 4'd0) return 8'h00;
        if (inst == 0 && WriteEn && Waddr == a) return DataIn;
        return marr[inst][a];
    endfunction

    task automatic check_all();
        chk("busyA", 32'(busy_a), 32'(sweep_pos < N));
        chk("busyB", 32'(busy_b), 32'(sweep_pos < N));
        chk("dropA", 32'(drop_a), 32'(mdrop));
        chk("dropB", 32'(drop_b), 32'(mdrop));
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("rdA%0d", p), 32'(dout_a[p*W +: W]), 32'(exp_rd(0, Raddr[p*D +: D])));
            chk($sformatf("rdB%0d", p), 32'(dout_b[p*W +: W]), 32'(exp_rd(1, Raddr[p*D +: D])));
        end
    endtask

    task automatic model_edge();
        bit busy;
        if (Reset) begin
            mdrop = 1'b0;
        end else begin
            busy  = (sweep_pos < N);
            mdrop = WriteEn && busy;
            if (busy) begin
                marr[0][sweep_pos] = 8'h00;
                marr[1][sweep_pos] = 8'h00;
                sweep_pos++;
            end else if (WriteEn) begin
                if (Waddr != 4'd0) marr[0][Waddr] = DataIn;
                marr[1][Waddr] = DataIn;
            end
        end
    endtask

    task automatic cycle();
        @(negedge Clk);
        check_all();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic set_reset(input bit v);
        Reset = v;
        if (v) begin
            sweep_pos = 0;
            mdrop     = 1'b0;
        end
    endtask

    // Counts cycles with InitBusy high after release, bounded; returns the count.
    task automatic count_busy(output int nb, input bit inject_write);
        nb = 0;
        for (int e = 0; e < 40; e++) begin
            if (!busy_a) break;
            nb++;
            if (inject_write && e == 3) begin
                WriteEn = 1'b1; Waddr = 4'd5; DataIn = 8'hA7;
            end
            if (inject_write && e == 4) begin
                WriteEn = 1'b0;
                chk("drop_pulse", 32'(drop_a), 32'd1);
            end
            if (inject_write && e == 5) chk("drop_clear", 32'(drop_a), 32'd0);
            cycle();
        end
    endtask

    initial begin
        int nb;
        Reset = 1'b1; WriteEn = 1'b0; Waddr = '0; DataIn = '0; Raddr = '0;
        sweep_pos = 0; mdrop = 1'b0;
        for (int i = 0; i < N; i++) begin
            marr[0][i] = 8'h00;
            marr[1][i] = 8'h00;
        end

        // Reset held 3 cycles, then the sweep with a dropped write at edge 4.
        #1;
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_drop", 32'(drop_a), 32'd0);
        repeat (3) cycle();
        set_reset(1'b0);
        count_busy(nb, 1'b1);
        chk("busy_len", 32'(nb), 32'd16);
        for (int a = 0; a < N; a++) begin
            Raddr = {4'(a), 4'(a), 4'(a)};
            #1;
            chk("post_sweep_zero", 32'(dout_a), 32'h0);
            cycle();
        end

        // Same-cycle forwarding versus next-cycle visibility.
        WriteEn = 1'b1; Waddr = 4'd3; DataIn = 8'h5C; Raddr = {4'd3, 4'd3, 4'd7};
        #1;
        chk("byp_same", 32'(dout_a), 32'h5C5C00);
        chk("nobyp_same", 32'(dout_b), 32'h000000);
        cycle();
        WriteEn = 1'b0;
        #1;
        chk("nobyp_next", 32'(dout_b), 32'h5C5C00);
        chk("byp_next", 32'(dout_a), 32'h5C5C00);
        cycle();

        // Write to r0: discarded on the zero-r0 instance, stored on the other.
        WriteEn = 1'b1; Waddr = 4'd0; DataIn = 8'hFF; Raddr = '0;
        cycle();
        WriteEn = 1'b0;
        #1;
        chk("r0_zero", 32'(dout_a), 32'h0);
        chk("r0_nodrop", 32'(drop_a), 32'd0);
        chk("r0_plain", 32'(dout_b), 32'hFFFFFF);
        cycle();

        // Fill, then reset in the middle of a fresh sweep.
        for (int i = 0; i < N; i++) begin
            WriteEn = 1'b1; Waddr = 4'(i); DataIn = 8'(8'h10 + i);
            Raddr = {4'(i), 4'(i - 1), 4'(15 - i)};
            cycle();
        end
        WriteEn = 1'b0; Raddr = {4'd9, 4'd15, 4'd1};
        #1;
        chk("fillA", 32'(dout_a), 32'h191F11);
        chk("fillB", 32'(dout_b), 32'h191F11);
        cycle();
        set_reset(1'b1);
        cycle();
        set_reset(1'b0);
        repeat (9) cycle();
        set_reset(1'b1);
        cycle();
        set_reset(1'b0);
        count_busy(nb, 1'b0);
        chk("busy_len_restart", 32'(nb), 32'd16);
        for (int a = 0; a < N; a++) begin
            Raddr = {4'(a), 4'(15 - a), 4'(a)};
            #1;
            chk("restart_zeroB", 32'(dout_b), 32'h0);
            cycle();
        end

        // Random traffic against the model, with rare resets.
        for (int c = 0; c < 2000; c++) begin
            set_reset($urandom_range(0, 399) == 0);
            WriteEn = ($urandom_range(0, 3) != 0);
            Waddr   = 4'($urandom);
            DataIn  = 8'($urandom);
            for (int p = 0; p < NR; p++)
                Raddr[p*D +: D] = ($urandom_range(0, 1) != 0) ? Waddr : 4'($urandom);
            cycle();
        end
        set_reset(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
